rr_monitor: RTL and testbench

Parametrised round-robin checker for the arithmetic testbench, successor to the fixed 32-bit, four-lane monitor. It accepts one DUT transaction per cycle (operands plus DUT result), deals each one to a non-pipelined multi-cycle reference lane, compares the lane's result against the DUT result, and reports a per-transaction pass/fail, running counters and (optionally) the first failing transaction. All lanes run on the single `clk` with clock enables; there are no derived or gated clocks.

---
 rtl/rr_monitor_pkg.sv | 23 ++
 rtl/rr_monitor_if.sv | 57 +++++
 rtl/rr_monitor_ref_lane.sv | 110 +++++++++++
 rtl/rr_monitor.sv | 172 +++++++++++++++++
 tb/tb_rr_monitor.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rr_monitor_pkg.sv
// rr_monitor_pkg: shared constants and types for the round-robin checker.
//   MODE_*       : operation selector values for the MODE parameter
//   CNT_W        : width of the saturating check/mismatch counters
//   lane_state_t : reference lane state
//   ceil_div     : integer ceiling division for elaboration-time sizing
package rr_monitor_pkg;

  localparam int unsigned MODE_ADD = 0;
  localparam int unsigned MODE_SUB = 1;
  localparam int unsigned MODE_MUL = 2;

  localparam int unsigned CNT_W = 32;

  typedef enum logic {
    LANE_IDLE = 1'b0,
    LANE_BUSY = 1'b1
  } lane_state_t;

  function automatic int unsigned ceil_div(input int unsigned n, input int unsigned d);
    return (n + d - 1) / d;
  endfunction

endpackage

// File: rtl/rr_monitor_if.sv
// rr_monitor_if: transaction and result bundle for rr_monitor.
//   i_valid, i_dut_ia, i_dut_ib, i_dut_os : one DUT transaction per cycle
//   i_clear                              : synchronous clear of counters/capture
//   o_chk_valid, o_event                 : per-check pulse and mismatch flag
//   o_check_cnt, o_mismatch_cnt          : saturating counters
//   o_err_*                              : first-mismatch capture, present only
//                                          when RR_MONITOR_ERR_CAPTURE_EN is defined
// Modports: master drives transactions (bench / stimulus side),
//           slave is the monitor.
interface rr_monitor_if
  import rr_monitor_pkg::*;
#(
  parameter int unsigned WIDTH = 32
);

  logic             i_valid;
  logic [WIDTH-1:0] i_dut_ia;
  logic [WIDTH-1:0] i_dut_ib;
  logic [WIDTH-1:0] i_dut_os;
  logic             i_clear;

  logic             o_chk_valid;
  logic             o_event;
  logic [CNT_W-1:0] o_check_cnt;
  logic [CNT_W-1:0] o_mismatch_cnt;

`ifdef RR_MONITOR_ERR_CAPTURE_EN
  logic             o_err_valid;
  logic [WIDTH-1:0] o_err_a;
  logic [WIDTH-1:0] o_err_b;
  logic [WIDTH-1:0] o_err_dut;
  logic [WIDTH-1:0] o_err_ref;

  modport master (
    output i_valid, i_dut_ia, i_dut_ib, i_dut_os, i_clear,
    input  o_chk_valid, o_event, o_check_cnt, o_mismatch_cnt,
    input  o_err_valid, o_err_a, o_err_b, o_err_dut, o_err_ref
  );

  modport slave (
    input  i_valid, i_dut_ia, i_dut_ib, i_dut_os, i_clear,
    output o_chk_valid, o_event, o_check_cnt, o_mismatch_cnt,
    output o_err_valid, o_err_a, o_err_b, o_err_dut, o_err_ref
  );
`else
  modport master (
    output i_valid, i_dut_ia, i_dut_ib, i_dut_os, i_clear,
    input  o_chk_valid, o_event, o_check_cnt, o_mismatch_cnt
  );

  modport slave (
    input  i_valid, i_dut_ia, i_dut_ib, i_dut_os, i_clear,
    output o_chk_valid, o_event, o_check_cnt, o_mismatch_cnt
  );
`endif

endinterface

// File: rtl/rr_monitor_ref_lane.sv
// ref_lane: one non-pipelined reference lane of rr_monitor.
//   clk, reset        : clock, asynchronous active-high reset
//   i_load            : capture i_a/i_b/i_os and start a LATENCY-cycle computation
//   o_done            : one-cycle pulse, registered, LATENCY edges after the load
//   o_mismatch        : reference result differs from stored DUT result (with o_done)
//   o_ref,o_a,o_b,o_os: result/operands of the completed transaction; present only
//                       when RR_MONITOR_ERR_CAPTURE_EN is defined
// Multiply is shift-add, CHUNK multiplier bits per cycle, so the product is
// complete after exactly LATENCY steps. Add/subtract are formed on the last step.
module ref_lane
  import rr_monitor_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned LATENCY = 4,
  parameter int unsigned MODE    = MODE_ADD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_os,
  output logic             o_done,
  output logic             o_mismatch
`ifdef RR_MONITOR_ERR_CAPTURE_EN
  ,
  output logic [WIDTH-1:0] o_ref,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b,
  output logic [WIDTH-1:0] o_os
`endif
);

  localparam int unsigned CHUNK = ceil_div(WIDTH, LATENCY);
  localparam int unsigned CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  lane_state_t      state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, os_q, acc_q;

  logic [WIDTH-1:0] acc_next, ref_final, a_bits, b_bits;
  int unsigned      base;

  // Step index runs 0..LATENCY-1 while cnt_q counts LATENCY-1..0.
  always_comb begin
    base     = (LATENCY - 1 - 32'(cnt_q)) * CHUNK;
    a_bits   = a_q << base;
    b_bits   = b_q >> base;
    acc_next = acc_q;
    for (int unsigned j = 0; j < CHUNK; j++) begin
      if (b_bits[0]) acc_next = acc_next + a_bits;
      a_bits = a_bits << 1;
      b_bits = b_bits >> 1;
    end
    case (MODE)
      MODE_ADD: ref_final = a_q + b_q;
      MODE_SUB: ref_final = a_q - b_q;
      default:  ref_final = acc_next;
    endcase
  end

  // A reload may land on the finishing edge (pointer wrapped back here);
  // the finished result is latched into the output registers first so the
  // new operands can overwrite a_q/b_q/os_q on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= LANE_IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      os_q       <= '0;
      acc_q      <= '0;
      o_done     <= 1'b0;
      o_mismatch <= 1'b0;
`ifdef RR_MONITOR_ERR_CAPTURE_EN
      o_ref      <= '0;
      o_a        <= '0;
      o_b        <= '0;
      o_os       <= '0;
`endif
    end else begin
      o_done <= 1'b0;
      if (state_q == LANE_BUSY) begin
        if (cnt_q == '0) begin
          o_done     <= 1'b1;
          o_mismatch <= (ref_final != os_q);
`ifdef RR_MONITOR_ERR_CAPTURE_EN
          o_ref      <= ref_final;
          o_a        <= a_q;
          o_b        <= b_q;
          o_os       <= os_q;
`endif
          state_q    <= LANE_IDLE;
        end else begin
          cnt_q <= cnt_q - 1'b1;
          acc_q <= acc_next;
        end
      end
      if (i_load) begin
        state_q <= LANE_BUSY;
        cnt_q   <= CW'(LATENCY - 1);
        acc_q   <= '0;
        a_q     <= i_a;
        b_q     <= i_b;
        os_q    <= i_os;
      end
    end
  end

endmodule

// File: rtl/rr_monitor.sv
// rr_monitor: round-robin arithmetic result checker.
//   clk, reset : clock, asynchronous active-high reset
//   mon        : rr_monitor_if.slave (transactions in; pulse, flag, counters out)
// Parameters: WIDTH (8..64), NUM_SUB_MON (2..16), REF_LATENCY (1..NUM_SUB_MON),
//             MODE (0 add, 1 subtract, 2 multiply low half).
// Each valid transaction is dealt to the lane named by a one-hot pointer; the
// pointer advances only on valid cycles. Lanes share one latency so at most one
// completes per cycle and completions come out in input order.
// Optional first-mismatch capture: define RR_MONITOR_ERR_CAPTURE_EN.
module rr_monitor
  import rr_monitor_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned NUM_SUB_MON = 4,
  parameter int unsigned REF_LATENCY = 4,
  parameter int unsigned MODE        = 0
) (
  input logic         clk,
  input logic         reset,
  rr_monitor_if.slave mon
);

  if (WIDTH < 8 || WIDTH > 64) begin : g_bad_width
    $error("rr_monitor: WIDTH out of range 8..64");
  end
  if (NUM_SUB_MON < 2 || NUM_SUB_MON > 16) begin : g_bad_lanes
    $error("rr_monitor: NUM_SUB_MON out of range 2..16");
  end
  if (REF_LATENCY < 1 || REF_LATENCY > NUM_SUB_MON) begin : g_bad_latency
    $error("rr_monitor: REF_LATENCY must be 1..NUM_SUB_MON");
  end
  if (MODE > MODE_MUL) begin : g_bad_mode
    $error("rr_monitor: MODE must be 0, 1 or 2");
  end

  logic [NUM_SUB_MON-1:0] ptr_q;
  logic [NUM_SUB_MON-1:0] lane_done;
  logic [NUM_SUB_MON-1:0] lane_mis;

  logic             chk_valid_q;
  logic             event_q;
  logic [CNT_W-1:0] check_cnt_q;
  logic [CNT_W-1:0] mis_cnt_q;

  logic any_done;
  logic sel_mis;

`ifdef RR_MONITOR_ERR_CAPTURE_EN
  logic [WIDTH-1:0] lane_ref [NUM_SUB_MON];
  logic [WIDTH-1:0] lane_a   [NUM_SUB_MON];
  logic [WIDTH-1:0] lane_b   [NUM_SUB_MON];
  logic [WIDTH-1:0] lane_os  [NUM_SUB_MON];
  logic [WIDTH-1:0] sel_ref, sel_a, sel_b, sel_os;
  logic             err_valid_q;
  logic [WIDTH-1:0] err_a_q, err_b_q, err_dut_q, err_ref_q;
`endif

  for (genvar g = 0; g < NUM_SUB_MON; g++) begin : g_lane
    ref_lane #(
      .WIDTH   (WIDTH),
      .LATENCY (REF_LATENCY),
      .MODE    (MODE)
    ) u_lane (
      .clk        (clk),
      .reset      (reset),
      .i_load     (mon.i_valid & ptr_q[g]),
      .i_a        (mon.i_dut_ia),
      .i_b        (mon.i_dut_ib),
      .i_os       (mon.i_dut_os),
      .o_done     (lane_done[g]),
      .o_mismatch (lane_mis[g])
`ifdef RR_MONITOR_ERR_CAPTURE_EN
      ,
      .o_ref      (lane_ref[g]),
      .o_a        (lane_a[g]),
      .o_b        (lane_b[g]),
      .o_os       (lane_os[g])
`endif
    );
  end

  // At most one lane is done per cycle, so an AND-OR mux is sufficient.
  always_comb begin
    any_done = |lane_done;
    sel_mis  = 1'b0;
`ifdef RR_MONITOR_ERR_CAPTURE_EN
    sel_ref  = '0;
    sel_a    = '0;
    sel_b    = '0;
    sel_os   = '0;
`endif
    for (int unsigned i = 0; i < NUM_SUB_MON; i++) begin
      if (lane_done[i]) begin
        sel_mis = sel_mis | lane_mis[i];
`ifdef RR_MONITOR_ERR_CAPTURE_EN
        sel_ref = sel_ref | lane_ref[i];
        sel_a   = sel_a   | lane_a[i];
        sel_b   = sel_b   | lane_b[i];
        sel_os  = sel_os  | lane_os[i];
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= NUM_SUB_MON'(1);
    end else if (mon.i_valid) begin
      ptr_q <= {ptr_q[NUM_SUB_MON-2:0], ptr_q[NUM_SUB_MON-1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chk_valid_q <= 1'b0;
      event_q     <= 1'b0;
    end else begin
      chk_valid_q <= any_done;
      event_q     <= any_done & sel_mis;
    end
  end

  // Clear has priority over a completing check on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      check_cnt_q <= '0;
      mis_cnt_q   <= '0;
    end else if (mon.i_clear) begin
      check_cnt_q <= '0;
      mis_cnt_q   <= '0;
    end else if (any_done) begin
      if (check_cnt_q != '1) check_cnt_q <= check_cnt_q + 1'b1;
      if (sel_mis && mis_cnt_q != '1) mis_cnt_q <= mis_cnt_q + 1'b1;
    end
  end

`ifdef RR_MONITOR_ERR_CAPTURE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_valid_q <= 1'b0;
      err_a_q     <= '0;
      err_b_q     <= '0;
      err_dut_q   <= '0;
      err_ref_q   <= '0;
    end else if (mon.i_clear) begin
      err_valid_q <= 1'b0;
      err_a_q     <= '0;
      err_b_q     <= '0;
      err_dut_q   <= '0;
      err_ref_q   <= '0;
    end else if (any_done && sel_mis && !err_valid_q) begin
      err_valid_q <= 1'b1;
      err_a_q     <= sel_a;
      err_b_q     <= sel_b;
      err_dut_q   <= sel_os;
      err_ref_q   <= sel_ref;
    end
  end

  assign mon.o_err_valid = err_valid_q;
  assign mon.o_err_a     = err_a_q;
  assign mon.o_err_b     = err_b_q;
  assign mon.o_err_dut   = err_dut_q;
  assign mon.o_err_ref   = err_ref_q;
`endif

  assign mon.o_chk_valid    = chk_valid_q;
  assign mon.o_event        = event_q;
  assign mon.o_check_cnt    = check_cnt_q;
  assign mon.o_mismatch_cnt = mis_cnt_q;

endmodule

// File: tb/tb_rr_monitor.sv
// tb_rr_monitor: self-checking bench for rr_monitor.
// Main instance: add, WIDTH=32, 4 lanes, latency 4, checked every cycle against
// a queue of expected completions (due cycle, mismatch, operands).
// Side instances: subtract (WIDTH=8, latency 1) and multiply (WIDTH=8, latency 3)
// checked one transaction at a time.
module tb_rr_monitor;
  import rr_monitor_pkg::*;

  localparam int unsigned L   = 4;
  localparam int unsigned LS  = 1;
  localparam int unsigned LM  = 3;

  logic clk;
  logic reset;

  rr_monitor_if #(.WIDTH(32)) ifa ();
  rr_monitor_if #(.WIDTH(8))  ifs ();
  rr_monitor_if #(.WIDTH(8))  ifm ();

  rr_monitor #(.WIDTH(32), .NUM_SUB_MON(4), .REF_LATENCY(L), .MODE(MODE_ADD))
    dut_add (.clk(clk), .reset(reset), .mon(ifa));
  rr_monitor #(.WIDTH(8), .NUM_SUB_MON(2), .REF_LATENCY(LS), .MODE(MODE_SUB))
    dut_sub (.clk(clk), .reset(reset), .mon(ifs));
  rr_monitor #(.WIDTH(8), .NUM_SUB_MON(3), .REF_LATENCY(LM), .MODE(MODE_MUL))
    dut_mul (.clk(clk), .reset(reset), .mon(ifm));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model for the add instance ----------------
  typedef struct {
    longint      due;
    logic        mis;
    logic [31:0] a, b, os, rf;
  } exp_t;

  exp_t        q[$];
  longint      cyc = 0;
  logic        clr_snap = 1'b0;
  bit          chk_en = 1'b0;
  bit          due_now;
  logic [31:0] m_chk = '0, m_mis = '0;
  logic        m_ev = 1'b0;
  logic [31:0] m_ea, m_eb, m_eo, m_er;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    clr_snap <= ifa.i_clear;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      due_now = (q.size() > 0) && (q[0].due == cyc);
      chk("chk_valid", ifa.o_chk_valid, due_now);
      if (due_now) chk("event", ifa.o_event, q[0].mis);
      if (clr_snap) begin
        m_chk = '0;
        m_mis = '0;
        m_ev  = 1'b0;
      end else if (due_now) begin
        if (m_chk != 32'hFFFF_FFFF) m_chk = m_chk + 1;
        if (q[0].mis && m_mis != 32'hFFFF_FFFF) m_mis = m_mis + 1;
        if (q[0].mis && !m_ev) begin
          m_ev = 1'b1;
          m_ea = q[0].a;
          m_eb = q[0].b;
          m_eo = q[0].os;
          m_er = q[0].rf;
        end
      end
      if (due_now) void'(q.pop_front());
      chk("check_cnt", ifa.o_check_cnt, m_chk);
      chk("mismatch_cnt", ifa.o_mismatch_cnt, m_mis);
`ifdef RR_MONITOR_ERR_CAPTURE_EN
      chk("err_valid", ifa.o_err_valid, m_ev);
      if (m_ev) begin
        chk("err_a", ifa.o_err_a, m_ea);
        chk("err_b", ifa.o_err_b, m_eb);
        chk("err_dut", ifa.o_err_dut, m_eo);
        chk("err_ref", ifa.o_err_ref, m_er);
      end
`endif
    end
  end

  task automatic drv_add(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] os, input logic clr);
    exp_t e;
    @(negedge clk);
    ifa.i_valid  = v;
    ifa.i_dut_ia = a;
    ifa.i_dut_ib = b;
    ifa.i_dut_os = os;
    ifa.i_clear  = clr;
    if (v) begin
      e.due = cyc + L + 2;
      e.a   = a;
      e.b   = b;
      e.os  = os;
      e.rf  = a + b;
      e.mis = (os != e.rf);
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drv_add(1'b0, '0, '0, '0, 1'b0);
  endtask

  // ---------------- single-shot checks for the 8-bit instances ----------------
  int sub_n = 0;
  int mul_n = 0;

  task automatic one_sub(input logic [7:0] a, input logic [7:0] b, input logic [7:0] os);
    int lat;
    logic [7:0] r;
    @(negedge clk);
    ifs.i_valid = 1'b1; ifs.i_dut_ia = a; ifs.i_dut_ib = b; ifs.i_dut_os = os;
    @(negedge clk);
    ifs.i_valid = 1'b0;
    lat = 1;
    while (!ifs.o_chk_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    r = a - b;
    sub_n++;
    chk("sub_latency", lat, LS + 2);
    chk("sub_event", ifs.o_event, (os != r));
    chk("sub_check_cnt", ifs.o_check_cnt, sub_n);
  endtask

  task automatic one_mul(input logic [7:0] a, input logic [7:0] b, input logic [7:0] os);
    int lat;
    logic [15:0] p;
    @(negedge clk);
    ifm.i_valid = 1'b1; ifm.i_dut_ia = a; ifm.i_dut_ib = b; ifm.i_dut_os = os;
    @(negedge clk);
    ifm.i_valid = 1'b0;
    lat = 1;
    while (!ifm.o_chk_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    p = 16'(a) * 16'(b);
    mul_n++;
    chk("mul_latency", lat, LM + 2);
    chk("mul_event", ifm.o_event, (os != p[7:0]));
    chk("mul_check_cnt", ifm.o_check_cnt, mul_n);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a, b, s;
    logic [7:0]  a8, b8, r8;
    logic [15:0] p16;

    reset = 1'b1;
    ifa.i_valid = 1'b0; ifa.i_dut_ia = '0; ifa.i_dut_ib = '0; ifa.i_dut_os = '0; ifa.i_clear = 1'b0;
    ifs.i_valid = 1'b0; ifs.i_dut_ia = '0; ifs.i_dut_ib = '0; ifs.i_dut_os = '0; ifs.i_clear = 1'b0;
    ifm.i_valid = 1'b0; ifm.i_dut_ia = '0; ifm.i_dut_ib = '0; ifm.i_dut_os = '0; ifm.i_clear = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_chk_valid", ifa.o_chk_valid, 0);
    chk("rst_event", ifa.o_event, 0);
    chk("rst_check_cnt", ifa.o_check_cnt, 0);
    chk("rst_mismatch_cnt", ifa.o_mismatch_cnt, 0);
    chk("rst_ptr", dut_add.ptr_q, 4'b0001);
`ifdef RR_MONITOR_ERR_CAPTURE_EN
    chk("rst_err_valid", ifa.o_err_valid, 0);
`endif
    reset  = 1'b0;
    chk_en = 1'b1;

    // single transaction, expected clean
    drv_add(1'b1, 32'd5, 32'd7, 32'd12, 1'b0);
    idle(8);

    // 16 back-to-back, 9th wrong
    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      b = $urandom;
      s = a + b;
      drv_add(1'b1, a, b, (i == 8) ? s + 32'd3 : s, 1'b0);
    end
    idle(8);

    // random valid gaps, occasional wrong results and clears
    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      b = $urandom;
      s = a + b;
      if ($urandom_range(0, 7) == 0) s = s ^ (32'd1 << $urandom_range(0, 31));
      drv_add(1'($urandom_range(0, 1)), a, b, s, ($urandom_range(0, 39) == 0));
    end
    idle(8);

    // clear on the same edge as a completion
    drv_add(1'b1, 32'd3, 32'd4, 32'd7, 1'b0);
    idle(L);
    drv_add(1'b0, '0, '0, '0, 1'b1);
    idle(1);
    chk("clear_wins_cnt", ifa.o_check_cnt, 0);
    idle(4);

    // saturation
    @(negedge clk);
    #2;
    force dut_add.check_cnt_q = 32'hFFFF_FFFE;
    force dut_add.mis_cnt_q   = 32'hFFFF_FFFE;
    m_chk = 32'hFFFF_FFFE;
    m_mis = 32'hFFFF_FFFE;
    #1;
    release dut_add.check_cnt_q;
    release dut_add.mis_cnt_q;
    for (int i = 0; i < 3; i++) drv_add(1'b1, 32'(i + 1), 32'd1, 32'd0, 1'b0);
    idle(8);
    chk("sat_check_cnt", ifa.o_check_cnt, 32'hFFFF_FFFF);
    chk("sat_mismatch_cnt", ifa.o_mismatch_cnt, 32'hFFFF_FFFF);

    // reset with three lanes busy
    for (int i = 0; i < 3; i++) drv_add(1'b1, 32'(i), 32'd10, 32'(i + 10), 1'b0);
    @(posedge clk);
    #2;
    reset       = 1'b1;
    chk_en      = 1'b0;
    ifa.i_valid = 1'b0;
    #1;
    chk("mid_rst_chk_valid", ifa.o_chk_valid, 0);
    chk("mid_rst_event", ifa.o_event, 0);
    chk("mid_rst_check_cnt", ifa.o_check_cnt, 0);
    chk("mid_rst_mismatch_cnt", ifa.o_mismatch_cnt, 0);
    chk("mid_rst_ptr", dut_add.ptr_q, 4'b0001);
`ifdef RR_MONITOR_ERR_CAPTURE_EN
    chk("mid_rst_err_valid", ifa.o_err_valid, 0);
`endif
    q.delete();
    m_chk = '0;
    m_mis = '0;
    m_ev  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset  = 1'b0;
    chk_en = 1'b1;
    drv_add(1'b1, 32'd100, 32'd200, 32'd300, 1'b0);
    idle(1);
    chk("post_rst_ptr", dut_add.ptr_q, 4'b0010);
    chk("post_rst_lane0_busy", dut_add.g_lane[0].u_lane.state_q, LANE_BUSY);
    idle(10);

    // subtract / multiply truncation and random
    one_sub(8'h00, 8'h01, 8'hFF);
    one_sub(8'h05, 8'h03, 8'h01);
    for (int i = 0; i < 8; i++) begin
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      r8 = a8 - b8;
      one_sub(a8, b8, ($urandom_range(0, 2) == 0) ? r8 + 8'd1 : r8);
    end
    one_mul(8'h10, 8'h10, 8'h00);
    one_mul(8'h03, 8'h05, 8'h10);
    for (int i = 0; i < 8; i++) begin
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      p16 = 16'(a8) * 16'(b8);
      one_mul(a8, b8, ($urandom_range(0, 2) == 0) ? p16[7:0] ^ 8'h40 : p16[7:0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
